// File: rtl/input_conditioner_n.sv
// N-channel input conditioner: synchroniser, debounce filter and one-pulse edge FSM per channel.
// Define INPUT_COND_REPEAT_EN to add auto-repeat pulses on a held input.
module input_conditioner_n #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] a,
    output logic [N-1:0] pulse,
    output logic [N-1:0] level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    // Elaboration-time guard against parameter values the channel logic cannot represent.
    if (N < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("input_conditioner_n: illegal parameter value");
    end

`ifdef INPUT_COND_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic                   r_d;
        logic [CNT_W-1:0]       r_cnt;
        logic [1:0]             r_state;
`ifdef INPUT_COND_REPEAT_EN
        logic [RPT_W-1:0]       r_rpt;
        logic                   r_from_repeat;
`endif

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], a[i]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_d   <= 1'b0;
                r_cnt <= '0;
            end else if (w_s == r_d) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_d   <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Edge FSM reacts to the registered debounced level, so the pulse lands one edge after level rises.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_state       <= ST_IDLE;
`ifdef INPUT_COND_REPEAT_EN
                r_rpt         <= '0;
                r_from_repeat <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_d) begin
                            r_state       <= ST_FIRE;
`ifdef INPUT_COND_REPEAT_EN
                            r_from_repeat <= 1'b0;
`endif
                        end
                    end
                    ST_FIRE: begin
                        if (!r_d) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_HELD;
`ifdef INPUT_COND_REPEAT_EN
                            r_rpt   <= r_from_repeat ? RPT_W'(REPEAT_PERIOD - 2)
                                                     : RPT_W'(REPEAT_DELAY - 2);
`endif
                        end
                    end
                    ST_HELD: begin
                        if (!r_d) begin
                            r_state <= ST_IDLE;
`ifdef INPUT_COND_REPEAT_EN
                        end else if (r_rpt == '0) begin
                            r_state       <= ST_FIRE;
                            r_from_repeat <= 1'b1;
                        end else begin
                            r_rpt <= r_rpt - 1'b1;
`endif
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign pulse[i] = (r_state == ST_FIRE);
        assign level[i] = r_d;
    end

endmodule

// File: tb/tb_input_conditioner_n.sv
// Directed testbench for input_conditioner_n with default parameters; expected waveforms are
// written as edge-indexed tables counted from the first edge that samples the new input value.
module tb_input_conditioner_n;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] a;
    logic [3:0] pulse;
    logic [3:0] level;

    int vectors     = 0;
    int miscompares = 0;

    input_conditioner_n #(
        .N              (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .a    (a),
        .pulse(pulse),
        .level(level)
    );

    always #5 Clock = ~Clock;

    // Advance one rising edge and settle; inputs are changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_p;
        logic [3:0] exp_l;
        Reset = 1'b1;
        a     = 4'b1111;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (pulse !== 4'b0000 || level !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d pulse=%b level=%b expected 0000/0000", k, pulse, level);
            end
        end
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_l = (k >= 6) ? 4'b1111 : 4'b0000;
            exp_p = (k == 7) ? 4'b1111 : 4'b0000;
            vectors++;
            if (pulse !== exp_p || level !== exp_l) begin
                miscompares++;
                $display("FAIL reset_release edge=%0d pulse=%b level=%b expected %b/%b",
                         k, pulse, level, exp_p, exp_l);
            end
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_l = (k >= 6) ? 4'b0000 : 4'b1111;
            vectors++;
            if (pulse !== 4'b0000 || level !== exp_l) begin
                miscompares++;
                $display("FAIL reset_fall edge=%0d pulse=%b level=%b expected 0000/%b",
                         k, pulse, level, exp_l);
            end
        end
    endtask

    task automatic test_single_press();
        logic [3:0] exp_p;
        logic [3:0] exp_l;
        a = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_l = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_p = (k == 7) ? 4'b0001 : 4'b0000;
            vectors++;
            if (pulse !== exp_p || level !== exp_l) begin
                miscompares++;
                $display("FAIL single_press edge=%0d pulse=%b level=%b expected %b/%b",
                         k, pulse, level, exp_p, exp_l);
            end
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_l = (k >= 6) ? 4'b0000 : 4'b0001;
            vectors++;
            if (pulse !== 4'b0000 || level !== exp_l) begin
                miscompares++;
                $display("FAIL single_release edge=%0d pulse=%b level=%b expected 0000/%b",
                         k, pulse, level, exp_l);
            end
        end
    endtask

    // a[1] samples 1,1,0,0,1,1,0,0 then stays 1 from edge 9: level at edge 14, pulse at edge 15.
    task automatic test_bounce();
        logic [3:0] exp_p;
        logic [3:0] exp_l;
        for (int k = 1; k <= 22; k++) begin
            a = (k <= 8 && ((k - 1) / 2) % 2 == 1) ? 4'b0000 : 4'b0010;
            step();
            exp_l = (k >= 14) ? 4'b0010 : 4'b0000;
            exp_p = (k == 15) ? 4'b0010 : 4'b0000;
            vectors++;
            if (pulse !== exp_p || level !== exp_l) begin
                miscompares++;
                $display("FAIL bounce edge=%0d pulse=%b level=%b expected %b/%b",
                         k, pulse, level, exp_p, exp_l);
            end
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) step();
        vectors++;
        if (level !== 4'b0000) begin
            miscompares++;
            $display("FAIL bounce_release level=%b expected 0000", level);
        end
        // A 3-cycle glitch is one short of the debounce window and must leave no trace.
        for (int k = 1; k <= 14; k++) begin
            a = (k <= 3) ? 4'b0100 : 4'b0000;
            step();
            vectors++;
            if (pulse !== 4'b0000 || level !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch edge=%0d pulse=%b level=%b expected 0000/0000", k, pulse, level);
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] exp_p;
        for (int k = 1; k <= 14; k++) begin
            a = (k >= 4) ? 4'b1100 : 4'b0100;
            step();
            exp_p = (k == 7) ? 4'b0100 : (k == 10) ? 4'b1000 : 4'b0000;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL staggered edge=%0d pulse=%b expected %b", k, pulse, exp_p);
            end
        end
        vectors++;
        if (level !== 4'b1100) begin
            miscompares++;
            $display("FAIL staggered_level level=%b expected 1100", level);
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) step();
        a = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_p = (k == 7) ? 4'b1111 : 4'b0000;
            vectors++;
            if (pulse !== exp_p) begin
                miscompares++;
                $display("FAIL simultaneous edge=%0d pulse=%b expected %b", k, pulse, exp_p);
            end
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) step();
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_p;
        logic [3:0] exp_l;
        a = 4'b0001;
        for (int k = 1; k <= 6; k++) step();
        vectors++;
        if (level !== 4'b0001 || pulse !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_pre pulse=%b level=%b expected 0000/0001", pulse, level);
        end
        Reset = 1'b1;
        step();
        vectors++;
        if (pulse !== 4'b0000 || level !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_drop pulse=%b level=%b expected 0000/0000", pulse, level);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_l = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_p = (k == 7) ? 4'b0001 : 4'b0000;
            vectors++;
            if (pulse !== exp_p || level !== exp_l) begin
                miscompares++;
                $display("FAIL mid_reset_after edge=%0d pulse=%b level=%b expected %b/%b",
                         k, pulse, level, exp_p, exp_l);
            end
        end
        a = 4'b0000;
        for (int k = 1; k <= 10; k++) step();
    endtask

    // Release after 55 high samples: level falls after edge 61, before the would-be repeat at edge 63.
    task automatic test_repeat();
        logic [3:0] exp_p;
        logic [3:0] exp_l;
        bit         rep;
        for (int k = 1; k <= 75; k++) begin
            a = (k <= 55) ? 4'b0001 : 4'b0000;
            step();
`ifdef INPUT_COND_REPEAT_EN
            rep = (k >= 23 && k <= 55 && ((k - 23) % 8) == 0);
`else
            rep = 1'b0;
`endif
            exp_p = (k == 7 || rep) ? 4'b0001 : 4'b0000;
            exp_l = (k >= 6 && k <= 60) ? 4'b0001 : 4'b0000;
            vectors++;
            if (pulse !== exp_p || level !== exp_l) begin
                miscompares++;
                $display("FAIL repeat edge=%0d pulse=%b level=%b expected %b/%b",
                         k, pulse, level, exp_p, exp_l);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        a     = 4'b0000;
        #1;
        step();
        test_reset();
        test_single_press();
        test_bounce();
        test_independence();
        test_mid_reset();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
